div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Iterative restoring integer divider sequencer for the EX stage.
- Executes MIPS DIV/DIVU by stepping an internal au instance in subtract mode once per cycle, one quotient bit per step.
- Handshake is start/busy/done; the pipeline stalls on busy, and the HI/LO write path samples quotient/remainder on done.

Parameters:
- width, 32, operand width in bits; must be ≥ 2.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a divide; sampled only in IDLE.
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- dividend  input  width  numerator; sampled with start.
- divisor  input  width  denominator; sampled with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; results valid in this cycle.
- quotient  output  width  result quotient; held until the next accepted start.
- remainder  output  width  result remainder; held until the next accepted start.
- div_by_zero  output  1  set with done when divisor was 0; held with the results.

Behaviour:
- Reset (async, any state) forces:
  - state = IDLE, step counter = 0;
  - busy = 0, done = 0;
  - quotient = 0, remainder = 0, div_by_zero = 0;
  - all working registers = 0.
- An operation in flight at reset is discarded.
- States:
  - IDLE → RUN on start = 1 with divisor ≠ 0.
  - IDLE → DONE on start = 1 with divisor = 0.
  - RUN → DONE after exactly width steps (counter reaches width-1).
  - DONE → IDLE unconditionally after one cycle.
- Accept (IDLE, start = 1):
  - Latch magnitudes: |dividend| and |divisor| when is_signed, else the raw values.
  - Latch neg_q = is_signed & (dividend[msb] ^ divisor[msb]).
  - Latch neg_r = is_signed & dividend[msb].
  - Clear the partial remainder P (width bits) and the counter.
  - Magnitude of the most-negative value is 2^(width-1) as an unsigned number; no saturation.
- RUN step, per cycle:
  - T = {P, D[msb]} (width+1 bits).
  - au #(width+1) computes T − {0, |divisor|} with sub = 1.
  - If borrow_out = 0: P ← difference[width-1:0] and quotient bit = 1.
  - Else: P ← T[width-1:0] and quotient bit = 0.
  - D ← {D[width-2:0], quotient bit}.
  - Counter increments.
- DONE (one cycle):
  - done = 1.
  - quotient ← neg_q ? −D : D.
  - remainder ← neg_r ? −P : P.
  - div_by_zero ← 0.
  - Outputs update on the clock edge entering DONE, so they are valid while done = 1.
- Divide by zero:
  - Skips RUN entirely.
  - quotient = all ones.
  - remainder = the original dividend, un-negated.
  - div_by_zero = 1.
  - done asserts 1 cycle after the accepting edge.
- Latency:
  - Accepting edge at cycle 0.
  - done high in cycle width+1 (cycle 33 for width = 32).
  - busy low again in cycle width+2.
  - Back-to-back: a start in cycle width+2 is accepted.
- start while busy (RUN or DONE) is ignored; it is not queued.
- is_signed, dividend and divisor are don't-care after acceptance.
- Signed overflow (−2^(width-1) / −1): quotient = 0x80000000, remainder = 0, div_by_zero = 0.
- The remainder sign always follows the dividend; quotient truncates toward zero.

Test Plan:
- DIVU 100 / 7, start at cycle 0 → busy cycles 1–33; done only in cycle 33; quotient = 14, remainder = 2, div_by_zero = 0; outputs hold after done.
- DIV 0xFFFFFF9C (−100) / 7 → quotient = 0xFFFFFFF2 (−14), remainder = 0xFFFFFFFE (−2). Also cover DIV 100 / 0xFFFFFFF9 → quotient = 0xFFFFFFF2, remainder = 2.
- DIVU 0x12345678 / 0 → done in cycle 1; quotient = 0xFFFFFFFF, remainder = 0x12345678, div_by_zero = 1. A following DIVU 9 / 3 clears div_by_zero and gives quotient = 3, remainder = 0.
- DIV 0x80000000 / 0xFFFFFFFF → quotient = 0x80000000, remainder = 0. DIVU 0xFFFFFFFF / 1 → quotient = 0xFFFFFFFF, remainder = 0.
- Start DIVU 1000 / 3, pulse start with other operands in cycles 5 and 33 → both ignored; result is quotient = 333, remainder = 1. A start in cycle 34 is accepted.
- Assert reset asynchronously mid-RUN (cycle 10) → immediately busy = 0, done = 0, quotient = 0, remainder = 0. No done pulse follows. A new start after reset release completes normally in width+1 cycles.

Source files
------------

// File: rtl/div_seq.sv
// Iterative restoring divider for MIPS DIV/DIVU: one quotient bit per cycle via an au in subtract mode.
// Latency width+1 cycles from accept to done (1 cycle for divide by zero); start is ignored while busy.

module au #(
    parameter int width = 33
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             sub,
    output logic [width-1:0] result,
    output logic             borrow_out
);
    logic [width:0] full;

    assign full       = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{width{1'b0}}, sub};
    assign result     = full[width-1:0];
    // In subtract mode a missing carry means a < b.
    assign borrow_out = sub ? ~full[width] : full[width];
endmodule

module div_seq #(
    parameter int width = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [width-1:0] dividend,
    input  logic [width-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] quotient,
    output logic [width-1:0] remainder,
    output logic             div_by_zero
);
    localparam int cw = $clog2(width);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [cw-1:0]    count;
    logic [width-1:0] d_reg, p_reg, dvs_reg;
    logic             neg_q, neg_r;

    logic [width-1:0] dvd_mag, dvs_mag;
    logic [width:0]   t, diff;
    logic             borrow, q_bit, last_step, divisor_zero;
    logic [width-1:0] p_next, d_next;
    logic             diff_top_unused;

    assign dvd_mag      = (is_signed & dividend[width-1]) ? (~dividend + 1'b1) : dividend;
    assign dvs_mag      = (is_signed & divisor[width-1])  ? (~divisor + 1'b1)  : divisor;
    assign divisor_zero = (divisor == '0);
    assign last_step    = (count == cw'(width - 1));

    assign t = {p_reg, d_reg[width-1]};

    au #(.width(width + 1)) u_au (
        .a          (t),
        .b          ({1'b0, dvs_reg}),
        .sub        (1'b1),
        .result     (diff),
        .borrow_out (borrow)
    );

    // The restoring invariant P < |divisor| keeps a successful difference below 2^width.
    assign diff_top_unused = diff[width];
    assign q_bit  = ~borrow;
    assign p_next = q_bit ? diff[width-1:0] : t[width-1:0];
    assign d_next = {d_reg[width-2:0], q_bit};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = divisor_zero ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count       <= '0;
            d_reg       <= '0;
            p_reg       <= '0;
            dvs_reg     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        d_reg   <= dvd_mag;
                        dvs_reg <= dvs_mag;
                        p_reg   <= '0;
                        count   <= '0;
                        neg_q   <= is_signed & (dividend[width-1] ^ divisor[width-1]);
                        neg_r   <= is_signed & dividend[width-1];
                        if (divisor_zero) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    p_reg <= p_next;
                    d_reg <= d_next;
                    count <= count + cw'(1);
                    // Results load on the same edge as the final step so they are valid with done.
                    if (last_step) begin
                        quotient    <= neg_q ? (~d_next + 1'b1) : d_next;
                        remainder   <= neg_r ? (~p_next + 1'b1) : p_next;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, signed/unsigned results, divide by zero, ignored starts, async reset.
module tb_div_seq;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    int checks = 0;
    int failures = 0;

    div_seq #(.width(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    // Called at a negedge; the following posedge is the accepting edge (cycle 0).
    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        @(posedge clock);
        #1;
        start     = 1'b0;
        dividend  = 32'hDEAD_BEEF;
        divisor   = 32'h0;
    endtask

    // Returns the cycle in which done was seen (-1 on timeout) and cycles before it with busy low.
    task automatic wait_done(output int lat, output int busy_gaps);
        lat = 0;
        busy_gaps = 0;
        forever begin
            @(negedge clock);
            lat++;
            if (done) break;
            if (!busy) busy_gaps++;
            if (lat > 200) begin
                lat = -1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl busy=%b done=%b required 0 0", busy, done);
        end
        checks++;
        if (quotient !== 32'h0 || remainder !== 32'h0 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_data q=%h r=%h dbz=%b required 0 0 0", quotient, remainder, div_by_zero);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_divu;
        int lat, gaps;
        launch(1'b0, 32'd100, 32'd7);
        wait_done(lat, gaps);
        checks++;
        if (lat !== 33 || gaps !== 0) begin
            failures++;
            $display("FAIL divu_latency done_cycle=%0d busy_gaps=%0d required 33 0", lat, gaps);
        end
        checks++;
        if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL divu_100_7 q=%0d r=%0d dbz=%b required 14 2 0", quotient, remainder, div_by_zero);
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL divu_after busy=%b done=%b required 0 0", busy, done);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (quotient !== 32'd14 || remainder !== 32'd2) begin
            failures++;
            $display("FAIL divu_hold q=%0d r=%0d required 14 2", quotient, remainder);
        end
    endtask

    task automatic test_signed;
        int lat, gaps;
        launch(1'b1, 32'hFFFF_FF9C, 32'd7);
        wait_done(lat, gaps);
        checks++;
        if (quotient !== 32'hFFFF_FFF2 || remainder !== 32'hFFFF_FFFE || lat !== 33) begin
            failures++;
            $display("FAIL div_neg100_7 q=%h r=%h lat=%0d required fffffff2 fffffffe 33", quotient, remainder, lat);
        end
        @(negedge clock);
        launch(1'b1, 32'd100, 32'hFFFF_FFF9);
        wait_done(lat, gaps);
        checks++;
        if (quotient !== 32'hFFFF_FFF2 || remainder !== 32'd2) begin
            failures++;
            $display("FAIL div_100_neg7 q=%h r=%h required fffffff2 00000002", quotient, remainder);
        end
        @(negedge clock);
        launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, gaps);
        checks++;
        if (quotient !== 32'h8000_0000 || remainder !== 32'h0 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL div_overflow q=%h r=%h dbz=%b required 80000000 0 0", quotient, remainder, div_by_zero);
        end
        @(negedge clock);
        launch(1'b0, 32'hFFFF_FFFF, 32'd1);
        wait_done(lat, gaps);
        checks++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'h0) begin
            failures++;
            $display("FAIL divu_max_1 q=%h r=%h required ffffffff 0", quotient, remainder);
        end
        @(negedge clock);
    endtask

    task automatic test_div_zero;
        int lat, gaps;
        launch(1'b0, 32'h1234_5678, 32'd0);
        wait_done(lat, gaps);
        checks++;
        if (lat !== 1) begin
            failures++;
            $display("FAIL dbz_latency done_cycle=%0d required 1", lat);
        end
        checks++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'h1234_5678 || div_by_zero !== 1'b1) begin
            failures++;
            $display("FAIL dbz_result q=%h r=%h dbz=%b required ffffffff 12345678 1", quotient, remainder, div_by_zero);
        end
        @(negedge clock);
        launch(1'b0, 32'd9, 32'd3);
        wait_done(lat, gaps);
        checks++;
        if (quotient !== 32'd3 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL dbz_clear q=%0d r=%0d dbz=%b required 3 0 0", quotient, remainder, div_by_zero);
        end
        @(negedge clock);
    endtask

    task automatic test_back_to_back;
        int lat, gaps;
        int cyc;
        launch(1'b0, 32'd1000, 32'd3);
        cyc = 0;
        forever begin
            @(negedge clock);
            cyc++;
            if (done || cyc > 200) break;
            if (cyc == 5) begin
                start = 1'b1; dividend = 32'd77; divisor = 32'd5;
            end else begin
                start = 1'b0;
            end
        end
        checks++;
        if (cyc !== 33) begin
            failures++;
            $display("FAIL ignore_latency done_cycle=%0d required 33", cyc);
        end
        // Start pulse during the done cycle must not be taken.
        start = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
        checks++;
        if (quotient !== 32'd333 || remainder !== 32'd1) begin
            failures++;
            $display("FAIL ignore_result q=%0d r=%0d required 333 1", quotient, remainder);
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || quotient !== 32'd333) begin
            failures++;
            $display("FAIL ignore_done_start busy=%b q=%0d required 0 333", busy, quotient);
        end
        launch(1'b0, 32'd200, 32'd8);
        wait_done(lat, gaps);
        checks++;
        if (lat !== 33 || quotient !== 32'd25 || remainder !== 32'd0) begin
            failures++;
            $display("FAIL back_to_back lat=%0d q=%0d r=%0d required 33 25 0", lat, quotient, remainder);
        end
        @(negedge clock);
    endtask

    task automatic test_async_reset;
        int lat, gaps;
        int seen_done;
        launch(1'b0, 32'd500, 32'd5);
        repeat (10) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'h0 || remainder !== 32'h0) begin
            failures++;
            $display("FAIL async_reset busy=%b done=%b q=%h r=%h required 0 0 0 0", busy, done, quotient, remainder);
        end
        @(negedge clock);
        reset = 1'b0;
        seen_done = 0;
        repeat (40) begin
            @(negedge clock);
            if (done || busy) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            failures++;
            $display("FAIL reset_discard active_cycles=%0d required 0", seen_done);
        end
        launch(1'b1, 32'hFFFF_FFF6, 32'd3);
        wait_done(lat, gaps);
        checks++;
        if (lat !== 33 || quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL post_reset lat=%0d q=%h r=%h required 33 fffffffd ffffffff", lat, quotient, remainder);
        end
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_divu();
        test_signed();
        test_div_zero();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
